stopwatch_ctrl: RTL and testbench

//   Front-panel sequencer for the stopwatch datapath. Debounces two raw pushbuttons, runs the

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl_button_debounce.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 92 +++++++++
 tb/tb_stopwatch_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch front-panel controller: FSM state encoding,
// button indices and the registered output bundle.
package stopwatch_pkg;

  localparam int STATE_W = 2;
  localparam int NUM_BTN = 2;
  localparam int BTN_SS  = 0;
  localparam int BTN_LC  = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LAP     = 2'd3
  } state_e;

  typedef struct packed {
    logic run;
    logic clear;
    logic lap_capture;
    logic lap_hold;
  } ctrl_out_t;

  // The counter keeps advancing while the display is frozen on a lap.
  function automatic logic state_counts(state_e s);
    return (s == ST_RUNNING) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Panel-side bundle: raw buttons in, stopwatch/display controls and debug state out.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               btn_start_stop;
  logic               btn_lap_clear;
  logic               run;
  logic               clear;
  logic               lap_capture;
  logic               lap_hold;
  logic [STATE_W-1:0] state;

  modport master (
    output btn_start_stop, btn_lap_clear,
    input  run, clear, lap_capture, lap_hold, state
  );

  modport slave (
    input  btn_start_stop, btn_lap_clear,
    output run, clear, lap_capture, lap_hold, state
  );

endinterface

// File: rtl/stopwatch_ctrl_button_debounce.sv
// One pushbutton: 2-FF synchronizer, stability counter and a registered
// single-cycle press pulse on each accepted rising level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      press     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
      level_d   <= level;
      press     <= level & ~level_d;
      // Any return to the accepted level restarts the stability window.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel sequencer: debounces start/stop and lap/clear buttons and
// runs the IDLE/RUNNING/PAUSED/LAP machine driving run, clear and lap display controls.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  stopwatch_ctrl_if.slave  sw
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] level_unused;

  assign btn_raw[BTN_SS] = sw.btn_start_stop;
  assign btn_raw[BTN_LC] = sw.btn_lap_clear;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_raw (btn_raw[b]),
      .level   (level_unused[b]),
      .press   (press[b])
    );
  end

  state_e    state_q, state_d;
  ctrl_out_t out_q,   out_d;
  logic      ss, lc;

  assign ss = press[BTN_SS];
  assign lc = press[BTN_LC];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Start/stop has priority; a coincident lap/clear press is dropped.
  always_comb begin
    state_d = state_q;
    out_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (ss)      state_d = ST_RUNNING;
        else if (lc) out_d.clear = 1'b1;
      end
      ST_RUNNING: begin
        if (ss) begin
          state_d = ST_PAUSED;
        end else if (lc) begin
          state_d           = ST_LAP;
          out_d.lap_capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss)      state_d = ST_PAUSED;
        else if (lc) state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (ss) begin
          state_d = ST_RUNNING;
        end else if (lc) begin
          state_d     = ST_IDLE;
          out_d.clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_d.run      = state_counts(state_d);
    out_d.lap_hold = (state_d == ST_LAP);
  end

  assign sw.run         = out_q.run;
  assign sw.clear       = out_q.clear;
  assign sw.lap_capture = out_q.lap_capture;
  assign sw.lap_hold    = out_q.lap_hold;
  assign sw.state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce window.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sw      (sw)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk2({tag, ".state"}, sw.state, 2'd0);
    chk1({tag, ".run"}, sw.run, 1'b0);
    chk1({tag, ".clear"}, sw.clear, 1'b0);
    chk1({tag, ".lap_capture"}, sw.lap_capture, 1'b0);
    chk1({tag, ".lap_hold"}, sw.lap_hold, 1'b0);
  endtask

  // Raise the requested buttons, check the transition 8 clocks later, release.
  task automatic press_and_check(input string tag, input logic s, input logic l,
                                 input logic [1:0] e_state, input logic e_run,
                                 input logic e_hold, input logic e_clr, input logic e_cap);
    sw.btn_start_stop = s;
    sw.btn_lap_clear  = l;
    tick(7);
    chk1({tag, ".pre_clear"}, sw.clear, 1'b0);
    chk1({tag, ".pre_cap"}, sw.lap_capture, 1'b0);
    tick(1);
    chk2({tag, ".state"}, sw.state, e_state);
    chk1({tag, ".run"}, sw.run, e_run);
    chk1({tag, ".lap_hold"}, sw.lap_hold, e_hold);
    chk1({tag, ".clear"}, sw.clear, e_clr);
    chk1({tag, ".lap_capture"}, sw.lap_capture, e_cap);
    tick(1);
    chk2({tag, ".state_hold"}, sw.state, e_state);
    chk1({tag, ".clear_drop"}, sw.clear, 1'b0);
    chk1({tag, ".cap_drop"}, sw.lap_capture, 1'b0);
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear  = 1'b0;
    tick(8);
  endtask

  initial begin
    sw.btn_start_stop = 1'b0;
    sw.btn_lap_clear  = 1'b0;
    reset_n = 1'b0;
    tick(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(2);
    chk2("post_reset.state", sw.state, 2'd0);

    // Held start/stop: latency 2+4+1 to press, +1 to outputs; only one press.
    sw.btn_start_stop = 1'b1;
    tick(7);
    chk1("latency.run_early", sw.run, 1'b0);
    chk2("latency.state_early", sw.state, 2'd0);
    tick(1);
    chk1("latency.run", sw.run, 1'b1);
    chk2("latency.state", sw.state, 2'd1);
    tick(12);
    chk2("held.state", sw.state, 2'd1);
    sw.btn_start_stop = 1'b0;
    tick(8);
    chk2("release.state", sw.state, 2'd1);
    chk1("release.run", sw.run, 1'b1);

    // Asynchronous reset while running.
    reset_n = 1'b0;
    #1;
    chk2("async_rst.state", sw.state, 2'd0);
    chk1("async_rst.run", sw.run, 1'b0);
    tick(1);
    chk_all_zero("rst_hold");
    reset_n = 1'b1;
    tick(3);
    chk2("rst_release.state", sw.state, 2'd0);
    chk1("rst_release.run", sw.run, 1'b0);

    // Reset in the middle of a debounce window.
    sw.btn_start_stop = 1'b1;
    tick(4);
    reset_n = 1'b0;
    sw.btn_start_stop = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk2("mid_db_rst.state", sw.state, 2'd0);

    // Short glitch is rejected.
    sw.btn_start_stop = 1'b1;
    tick(3);
    sw.btn_start_stop = 1'b0;
    tick(10);
    chk2("glitch.state", sw.state, 2'd0);
    chk1("glitch.run", sw.run, 1'b0);

    // Bounce then stable: one press, timed from the last edge.
    sw.btn_start_stop = 1'b1; tick(1);
    sw.btn_start_stop = 1'b0; tick(1);
    sw.btn_start_stop = 1'b1; tick(1);
    sw.btn_start_stop = 1'b0; tick(1);
    sw.btn_start_stop = 1'b1;
    tick(7);
    chk2("bounce.state_early", sw.state, 2'd0);
    tick(1);
    chk2("bounce.state", sw.state, 2'd1);
    chk1("bounce.run", sw.run, 1'b1);
    tick(10);
    sw.btn_start_stop = 1'b0;
    tick(8);
    chk2("bounce.single", sw.state, 2'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // ss, lc, lc, ss, lc -> 1,3,1,2,0
    press_and_check("seq1", 1'b1, 1'b0, ST_RUNNING, 1'b1, 1'b0, 1'b0, 1'b0);
    press_and_check("seq2", 1'b0, 1'b1, ST_LAP,     1'b1, 1'b1, 1'b0, 1'b1);
    press_and_check("seq3", 1'b0, 1'b1, ST_RUNNING, 1'b1, 1'b0, 1'b0, 1'b0);
    press_and_check("seq4", 1'b1, 1'b0, ST_PAUSED,  1'b0, 1'b0, 1'b0, 1'b0);
    press_and_check("seq5", 1'b0, 1'b1, ST_IDLE,    1'b0, 1'b0, 1'b1, 1'b0);

    // Simultaneous presses from IDLE: start/stop wins, lap/clear is not queued.
    press_and_check("simul", 1'b1, 1'b1, ST_RUNNING, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(10);
    chk2("simul.no_queue", sw.state, 2'd1);
    chk1("simul.no_cap", sw.lap_capture, 1'b0);

    press_and_check("to_pause", 1'b1, 1'b0, ST_PAUSED, 1'b0, 1'b0, 1'b0, 1'b0);
    press_and_check("to_idle",  1'b0, 1'b1, ST_IDLE,   1'b0, 1'b0, 1'b1, 1'b0);

    // lap/clear in IDLE: single clear pulse, stays idle.
    press_and_check("idle_clear", 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("idle_clear.run", sw.run, 1'b0);
    chk2("idle_clear.state", sw.state, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
